// File: rtl/mi_reg_responder.sv
// MI bus responder: byte-enabled register array with a fixed read latency and ARDY throttling.
// Define MI_REG_RESPONDER_STATS_EN to add read-only write/read counters just past the register array.
module mi_reg_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int META_WIDTH = 2,
  parameter int REG_COUNT  = 16,
  parameter int RD_LATENCY = 2,
  parameter int ARDY_GAP   = 0
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [DATA_WIDTH-1:0]   RX_DWR,
  input  logic [META_WIDTH-1:0]   RX_MWR,
  input  logic [ADDR_WIDTH-1:0]   RX_ADDR,
  input  logic                    RX_RD,
  input  logic                    RX_WR,
  input  logic [DATA_WIDTH/8-1:0] RX_BE,
  output logic                    RX_ARDY,
  output logic [DATA_WIDTH-1:0]   RX_DRD,
  output logic                    RX_DRDY
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BE_W);
  localparam int IDX_W = $clog2(REG_COUNT);
  localparam int GAP_W = (ARDY_GAP > 0) ? $clog2(ARDY_GAP + 1) : 1;

  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0] pdata_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pdata_d [RD_LATENCY];
`ifdef MI_REG_RESPONDER_STATS_EN
  logic [DATA_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [DATA_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
`endif

  logic [ADDR_WIDTH-1:0] index;
  logic [IDX_W-1:0]      reg_idx;
  logic                  in_range;
  logic                  accept;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_meta;

  assign unused_meta = ^RX_MWR;

  assign RX_ARDY  = RESET_N && (gap_q == '0);
  assign accept   = (RX_RD || RX_WR) && RX_ARDY;
  // RD and WR together is a protocol violation; it is handled as a plain write.
  assign wr_acc   = accept && RX_WR;
  assign rd_acc   = accept && RX_RD && !RX_WR;

  assign index    = RX_ADDR >> OFFS;
  assign reg_idx  = index[IDX_W-1:0];
  assign in_range = index < ADDR_WIDTH'(REG_COUNT);

  assign RX_DRDY  = vld_q[RD_LATENCY-1];
  assign RX_DRD   = vld_q[RD_LATENCY-1] ? pdata_q[RD_LATENCY-1] : '0;

  always_comb begin
    rd_data = '0;
    if (in_range) begin
      rd_data = regs_q[reg_idx];
    end
`ifdef MI_REG_RESPONDER_STATS_EN
    else if (index == ADDR_WIDTH'(REG_COUNT)) begin
      rd_data = wr_cnt_q;
    end else if (index == ADDR_WIDTH'(REG_COUNT + 1)) begin
      rd_data = rd_cnt_q + DATA_WIDTH'(1);
    end
`endif
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gap_d = gap_q;
    if (accept) begin
      gap_d = GAP_W'(ARDY_GAP);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end

    regs_d = regs_q;
    if (wr_acc && in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (RX_BE[b]) regs_d[reg_idx][8*b +: 8] = RX_DWR[8*b +: 8];
      end
    end

    vld_d[0]   = rd_acc;
    pdata_d[0] = rd_acc ? rd_data : '0;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i]   = vld_q[i-1];
      pdata_d[i] = pdata_q[i-1];
    end

`ifdef MI_REG_RESPONDER_STATS_EN
    wr_cnt_d = wr_cnt_q + (wr_acc ? DATA_WIDTH'(1) : DATA_WIDTH'(0));
    rd_cnt_d = rd_cnt_q + (rd_acc ? DATA_WIDTH'(1) : DATA_WIDTH'(0));
`endif
  end

  // NOTE: state is updated with non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      gap_q <= '0;
      vld_q <= '0;
      // NOTE: the register array is reset on purpose; reads after reset must return zero.
      for (int r = 0; r < REG_COUNT; r++) regs_q[r] <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pdata_q[i] <= '0;
`ifdef MI_REG_RESPONDER_STATS_EN
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
`endif
    end else begin
      gap_q   <= gap_d;
      vld_q   <= vld_d;
      regs_q  <= regs_d;
      pdata_q <= pdata_d;
`ifdef MI_REG_RESPONDER_STATS_EN
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mi_reg_responder.sv
// Directed bench for mi_reg_responder: one instance with ARDY_GAP=0, one with ARDY_GAP=2.
module tb_mi_reg_responder;

  logic        CLK = 1'b0;
  logic        RESET_N;
  always #5 CLK = ~CLK;

  logic [31:0] rx_dwr, rx_addr, rx_drd;
  logic [1:0]  rx_mwr;
  logic        rx_rd, rx_wr, rx_ardy, rx_drdy;
  logic [3:0]  rx_be;

  logic [31:0] g_dwr, g_addr, g_drd;
  logic [1:0]  g_mwr;
  logic        g_rd, g_wr, g_ardy, g_drdy;
  logic [3:0]  g_be;

  int n_tests = 0;
  int n_fail  = 0;

  mi_reg_responder #(.RD_LATENCY(2), .ARDY_GAP(0)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .RX_DWR(rx_dwr), .RX_MWR(rx_mwr), .RX_ADDR(rx_addr),
    .RX_RD(rx_rd), .RX_WR(rx_wr), .RX_BE(rx_be), .RX_ARDY(rx_ardy), .RX_DRD(rx_drd),
    .RX_DRDY(rx_drdy)
  );

  mi_reg_responder #(.RD_LATENCY(2), .ARDY_GAP(2)) u_gap (
    .CLK(CLK), .RESET_N(RESET_N), .RX_DWR(g_dwr), .RX_MWR(g_mwr), .RX_ADDR(g_addr),
    .RX_RD(g_rd), .RX_WR(g_wr), .RX_BE(g_be), .RX_ARDY(g_ardy), .RX_DRD(g_drd),
    .RX_DRDY(g_drdy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rx_rd = 1'b0; rx_wr = 1'b0; rx_addr = '0; rx_dwr = '0; rx_be = '0; rx_mwr = '0;
  endtask

  task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] dwr, input logic [3:0] be);
    rx_rd = rd; rx_wr = wr; rx_addr = addr; rx_dwr = dwr; rx_be = be; rx_mwr = 2'b11;
    #1;
  endtask

  task automatic write_op(input logic [31:0] addr, input logic [31:0] dwr, input logic [3:0] be);
    @(negedge CLK);
    req(1'b0, 1'b1, addr, dwr, be);
    check("wr_ardy", rx_ardy, 1'b1);
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge CLK);
    req(1'b1, 1'b0, addr, '0, '0);
    check({tag, "_ardy"}, rx_ardy, 1'b1);
    @(negedge CLK);
    idle();
    check({tag, "_early"}, rx_drdy, 1'b0);
    @(negedge CLK);
    check({tag, "_drdy"}, rx_drdy, 1'b1);
    check({tag, "_drd"}, rx_drd, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    RESET_N = 1'b0;
    idle();
    g_rd = 1'b0; g_wr = 1'b0; g_addr = '0; g_dwr = '0; g_be = '0; g_mwr = '0;
    repeat (3) @(negedge CLK);
    check("rst_ardy", rx_ardy, 1'b0);
    check("rst_drdy", rx_drdy, 1'b0);
    check("rst_drd", rx_drd, 32'h0);

    // Reset release and first read: data 0 two cycles later.
    RESET_N = 1'b1;
    req(1'b1, 1'b0, 32'h0, '0, '0);
    check("t1_ardy", rx_ardy, 1'b1);
    @(negedge CLK); idle();
    check("t1_early", rx_drdy, 1'b0);
    @(negedge CLK);
    check("t1_drdy", rx_drdy, 1'b1);
    check("t1_drd", rx_drd, 32'h0);
    @(negedge CLK);
    check("t1_drdy_off", rx_drdy, 1'b0);
    check("t1_drd_off", rx_drd, 32'h0);

    // Byte-enabled write, read in the very next cycle.
    write_op(32'h4, 32'hA1B2_C3D4, 4'b0101);
    read_check("t2", 32'h4, 32'h00B2_00D4);

    // Back-to-back reads after writing value = index.
    for (int i = 0; i < 8; i++) write_op(32'(i * 4), 32'(i), 4'hF);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (k < 8) req(1'b1, 1'b0, 32'(k * 4), '0, '0);
      else begin idle(); #1; end
      if (k < 2) check("t3_early", rx_drdy, 1'b0);
      else begin
        check("t3_drdy", rx_drdy, 1'b1);
        check("t3_drd", rx_drd, 32'(k - 2));
      end
    end
    @(negedge CLK);
    check("t3_drdy_off", rx_drdy, 1'b0);

    // RD and WR together: behaves as a write, no read data.
    @(negedge CLK);
    req(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF);
    @(negedge CLK); idle();
    check("rdwr_nodrdy1", rx_drdy, 1'b0);
    @(negedge CLK);
    check("rdwr_nodrdy2", rx_drdy, 1'b0);
    @(negedge CLK);
    check("rdwr_nodrdy3", rx_drdy, 1'b0);
    read_check("rdwr_data", 32'h8, 32'hDEAD_BEEF);
    read_check("unaligned", 32'hB, 32'hDEAD_BEEF);

    // Out-of-range write is dropped and must not alias onto register 0.
    write_op(32'h40, 32'hFFFF_FFFF, 4'hF);
    read_check("oor_alias", 32'h0, 32'h0);
`ifndef MI_REG_RESPONDER_STATS_EN
    read_check("oor_rd40", 32'h40, 32'h0);
    read_check("oor_rd44", 32'h44, 32'h0);
`endif
    read_check("oor_far", 32'h1000_0000, 32'h0);

    // Reset one cycle after a read is accepted: that read never returns.
    @(negedge CLK);
    req(1'b1, 1'b0, 32'h4, '0, '0);
    @(negedge CLK);
    idle();
    RESET_N = 1'b0;
    #1;
    check("t6_rst_ardy", rx_ardy, 1'b0);
    check("t6_rst_drdy", rx_drdy, 1'b0);
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("t6_nodrdy", rx_drdy, 1'b0);
      @(negedge CLK);
    end
    for (int k = 0; k < 18; k++) begin
      if (k < 16) req(1'b1, 1'b0, 32'(k * 4), '0, '0);
      else begin idle(); #1; end
      if (k >= 2) begin
        check("t6_drdy", rx_drdy, 1'b1);
        check("t6_zero", rx_drd, 32'h0);
      end
      @(negedge CLK);
    end
    idle();

`ifdef MI_REG_RESPONDER_STATS_EN
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    write_op(32'h0, 32'h1, 4'hF);
    read_check("st_rd1", 32'h0, 32'h1);
    read_check("st_rd2", 32'h0, 32'h1);
    read_check("st_rdcnt", 32'h44, 32'h3);
    read_check("st_wrcnt", 32'h40, 32'h1);
`endif

    // ARDY throttling with ARDY_GAP=2: pattern 1,0,0,1 with RD held.
    @(negedge CLK);
    g_wr = 1'b1; g_addr = 32'h8; g_dwr = 32'h1234_5678; g_be = 4'hF; #1;
    check("gap_ardy0", g_ardy, 1'b1);
    @(negedge CLK);
    g_wr = 1'b0; g_rd = 1'b1; g_be = '0; g_dwr = '0; #1;
    check("gap_ardy1", g_ardy, 1'b0);
    @(negedge CLK);
    check("gap_ardy2", g_ardy, 1'b0);
    check("gap_early2", g_drdy, 1'b0);
    @(negedge CLK);
    check("gap_ardy3", g_ardy, 1'b1);
    check("gap_early3", g_drdy, 1'b0);
    @(negedge CLK);
    g_rd = 1'b0; #1;
    check("gap_reload", g_ardy, 1'b0);
    check("gap_early4", g_drdy, 1'b0);
    @(negedge CLK);
    check("gap_drdy", g_drdy, 1'b1);
    check("gap_drd", g_drd, 32'h1234_5678);
    @(negedge CLK);
    check("gap_drdy_off", g_drdy, 1'b0);
    check("gap_ardy_back", g_ardy, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
